// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDUop encodings. The instruction decoder uses these same constants.
//     3'b111 is left unnamed and behaves as "no operation".
//   - FSM state encodings for the mdu sequencer.
package mdu_pkg;

   localparam logic [2:0] MDU_NONE  = 3'b000;
   localparam logic [2:0] MDU_MULT  = 3'b001;
   localparam logic [2:0] MDU_MULTU = 3'b010;
   localparam logic [2:0] MDU_DIV   = 3'b011;
   localparam logic [2:0] MDU_DIVU  = 3'b100;
   localparam logic [2:0] MDU_MTHI  = 3'b101;
   localparam logic [2:0] MDU_MTLO  = 3'b110;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit that owns the architectural HI/LO registers.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high; clears all state
//   A         in   32  rs operand (dividend / multiplicand / mthi-mtlo source)
//   B         in   32  rt operand (divisor / multiplier)
//   MDUop     in   3   operation select (mdu_pkg encodings)
//   Cancel    in   E-stage flush; suppresses an op sampled this cycle
//   Busy      out  multi-cycle op in progress (registered)
//   HI, LO    out  32  architectural HI/LO registers
//   dbg_state out  current FSM state
//
// Handshake: an op is accepted on a rising edge when the unit is IDLE,
// MDUop names an op and Cancel is low. While Busy the hazard unit holds
// MD-class instructions in D, so no op is presented during RUN. Any op that
// does arrive during RUN is dropped.
//
// The result is computed behaviourally from A/B at the accepting edge and
// parked in p_hi/p_lo. HI/LO keep their old values until the edge where the
// down-counter goes 1->0. There is no bypass from p_hi/p_lo to HI/LO.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDUop,
   input  logic        Cancel,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output state_e      dbg_state
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] p_hi_q, p_hi_d;
   logic [31:0] p_lo_q, p_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // Arithmetic on the current operands. It only matters at the accepting
   // edge, when it is captured into p_hi/p_lo.
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] a_s, b_s;
   logic        [31:0] res_hi, res_lo;

   always_comb begin
      a_s    = A;
      b_s    = B;
      prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prod_u = {32'd0, A} * {32'd0, B};
      res_hi = hi_q;
      res_lo = lo_q;
      case (MDUop)
         MDU_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MDU_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MDU_DIV: begin
            // Divisor 0 keeps HI/LO (defaults above). The single overflowing
            // case is pinned explicitly rather than left to the '/' operator.
            if (B == 32'd0) begin
               res_hi = hi_q;
               res_lo = lo_q;
            end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = a_s % b_s;
               res_lo = a_s / b_s;
            end
         end
         MDU_DIVU: begin
            if (B != 32'd0) begin
               res_hi = A % B;
               res_lo = A / B;
            end
         end
         default: begin
            res_hi = hi_q;
            res_lo = lo_q;
         end
      endcase
   end

   // Next-state / datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_hi_d  = p_hi_q;
      p_lo_d  = p_lo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (!Cancel) begin
               case (MDUop)
                  MDU_MULT, MDU_MULTU: begin
                     p_hi_d  = res_hi;
                     p_lo_d  = res_lo;
                     cnt_d   = MULT_CNT;
                     state_d = S_RUN;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     p_hi_d  = res_hi;
                     p_lo_d  = res_lo;
                     cnt_d   = DIV_CNT;
                     state_d = S_RUN;
                  end
                  MDU_MTHI: hi_d = A;
                  MDU_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            // Cancel is ignored here: a started op always completes.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               hi_d    = p_hi_q;
               lo_d    = p_lo_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         p_hi_q  <= 32'd0;
         p_lo_q  <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign Busy      = (state_q == S_RUN);
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for the mdu with hand-computed expected values.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  MDUop;
   logic        Cancel;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   state_e      dbg_state;

   int errors = 0;
   int checks = 0;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .MDUop     (MDUop),
      .Cancel    (Cancel),
      .Busy      (Busy),
      .HI        (HI),
      .LO        (LO),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The hazard unit never presents an op while Busy.
   always @(posedge clk) begin
      if (!reset && Busy && MDUop != MDU_NONE && MDUop != 3'b111) begin
         errors++;
         $display("FAIL op_during_busy: op=%0d presented while Busy=1, required none", MDUop);
      end
   end

   // ---------------- driver tasks ----------------
   // Drive an op at a falling edge; it is sampled at the next rising edge (E0).
   // Returns at the falling edge right after E0 with inputs back to idle.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cancel);
      @(negedge clk);
      MDUop  = op;
      A      = a;
      B      = b;
      Cancel = cancel;
      @(negedge clk);
      MDUop  = MDU_NONE;
      Cancel = 1'b0;
   endtask

   // Count falling edges that see Busy=1 (bounded) and note whether HI/LO
   // stayed at their pre-op values during that time. Ends at the first
   // falling edge with Busy=0.
   task automatic watch_busy(input logic cancel_run, output int cycles,
                             output logic held);
      logic [31:0] h0, l0;
      h0     = HI;
      l0     = LO;
      cycles = 0;
      held   = 1'b1;
      while (Busy && cycles < 40) begin
         if (HI !== h0 || LO !== l0) held = 1'b0;
         cycles++;
         Cancel = cancel_run;
         @(negedge clk);
      end
      Cancel = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1; A = '0; B = '0; MDUop = MDU_NONE; Cancel = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
      checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
   endtask

   task automatic test_mult;
      int cyc; logic held;
      issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      watch_busy(1'b0, cyc, held);
      checks++; if (cyc != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hold: HI/LO changed during Busy, want held"); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
   endtask

   task automatic test_div;
      int cyc; logic held;
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      watch_busy(1'b0, cyc, held);
      checks++; if (cyc != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", cyc); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL div_hold: HI/LO changed during Busy, want held"); end
      checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
      issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
      watch_busy(1'b0, cyc, held);
      checks++; if (cyc != 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 10", cyc); end
      checks++; if (LO !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo: got %h want 7ffffffc", LO); end
      checks++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 1", HI); end
   endtask

   task automatic test_div_corner;
      int cyc; logic held;
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      watch_busy(1'b0, cyc, held);
      checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
      issue(MDU_MTHI, 32'h11, 32'd0, 1'b0);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", Busy); end
      checks++; if (HI !== 32'h11) begin errors++; $display("FAIL mthi_hi: got %h want 11", HI); end
      issue(MDU_MTLO, 32'h22, 32'd0, 1'b0);
      checks++; if (LO !== 32'h22) begin errors++; $display("FAIL mtlo_lo: got %h want 22", LO); end
      issue(MDU_DIVU, 32'd5, 32'd0, 1'b0);
      watch_busy(1'b0, cyc, held);
      checks++; if (cyc != 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 10", cyc); end
      checks++; if (HI !== 32'h11) begin errors++; $display("FAIL divz_hi: got %h want 11", HI); end
      checks++; if (LO !== 32'h22) begin errors++; $display("FAIL divz_lo: got %h want 22", LO); end
   endtask

   task automatic test_cancel;
      int cyc; logic held;
      issue(MDU_MULT, 32'd9, 32'd9, 1'b1);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL cancel_mult_busy: got %b want 0", Busy); end
      repeat (6) @(negedge clk);
      checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL cancel_mult_hilo: got %h/%h want 11/22", HI, LO); end
      issue(MDU_MTLO, 32'h99, 32'd0, 1'b1);
      checks++; if (LO !== 32'h22) begin errors++; $display("FAIL cancel_mtlo: got %h want 22", LO); end
      // Cancel held high for the whole run, including the commit edge.
      issue(MDU_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
      watch_busy(1'b1, cyc, held);
      checks++; if (cyc != 5) begin errors++; $display("FAIL cancel_run_cycles: got %0d want 5", cyc); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cancel_run_hi: got %h want ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL cancel_run_lo: got %h want ffffffeb", LO); end
   endtask

   task automatic test_reset_mid_op;
      issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
      checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", HI, LO); end
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rst_no_commit: got %h/%h want 0/0", HI, LO); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy: got %b want 0", Busy); end
   endtask

   task automatic test_back_to_back;
      int cyc; logic held;
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      watch_busy(1'b0, cyc, held);
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold: HI/LO changed during Busy, want held at 0/0"); end
      checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_multu_hi: got %h want fffffffe", HI); end
      checks++; if (LO !== 32'd1) begin errors++; $display("FAIL b2b_multu_lo: got %h want 1", LO); end
      // First IDLE cycle: mthi goes straight in.
      MDUop = MDU_MTHI;
      A     = 32'd5;
      @(negedge clk);
      MDUop = MDU_NONE;
      checks++; if (HI !== 32'd5) begin errors++; $display("FAIL b2b_mthi_hi: got %h want 5", HI); end
      checks++; if (LO !== 32'd1) begin errors++; $display("FAIL b2b_mthi_lo: got %h want 1", LO); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_mthi_busy: got %b want 0", Busy); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_corner();
      test_cancel();
      test_reset_mid_op();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
